nios2_sysid_regs: RTL and testbench

//  Parametrised Avalon-MM system-identification slave for the Nios II SoC.

---
 rtl/nios2_sysid_regs.sv | 124 ++++++++++++
 tb/tb_nios2_sysid_regs.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/nios2_sysid_regs.sv
// Avalon-MM system-identification slave: fixed ID/timestamp, free-running 64-bit
// uptime with coherent LO/HI reads, scratch, control/status and pipelined reads.
module nios2_sysid_regs #(
  parameter logic [31:0] SYSTEM_ID    = 32'h5BBF_6F0A,
  parameter logic [31:0] TIMESTAMP    = 32'h0000_0000,
  parameter int          ADDR_W       = 3,
  parameter int          READ_LATENCY = 1,
  parameter int          TICK_DIV     = 50,
  parameter logic [63:0] UPTIME_INIT  = 64'h0
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] address,
  input  logic              read,
  input  logic              write,
  input  logic [31:0]       writedata,
  input  logic [3:0]        byteenable,
  output logic [31:0]       readdata,
  output logic              readdatavalid
);

  localparam int            PW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);

  logic [PW-1:0] r_prescale;
  logic [63:0]   r_uptime;
  logic [31:0]   r_hiShadow;
  logic [31:0]   r_scratch;
  logic          r_en;
  logic          r_ovf;
  logic          r_pipeValid [READ_LATENCY];
  logic [31:0]   r_pipeData  [READ_LATENCY];

  logic          w_wrScratch;
  logic          w_wrCtrl;
  logic          w_wrStatus;
  logic          w_clr;
  logic          w_tick;
  logic          w_ovfSet;
  logic          w_rdUpLo;
  logic [31:0]   w_rdata;

  assign w_wrScratch = write && (address == ADDR_W'(4));
  assign w_wrCtrl    = write && (address == ADDR_W'(5));
  assign w_wrStatus  = write && (address == ADDR_W'(6));
  assign w_clr       = w_wrCtrl && writedata[1];
  assign w_tick      = r_en && (r_prescale == PRE_LAST);
  // A clear in the same cycle suppresses the increment, so it cannot overflow.
  assign w_ovfSet    = w_tick && !w_clr && (&r_uptime);
  assign w_rdUpLo    = read && (address == ADDR_W'(2));

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_prescale <= '0;
      r_uptime   <= UPTIME_INIT;
    end else if (w_clr) begin
      r_prescale <= '0;
      r_uptime   <= '0;
    end else if (w_tick) begin
      r_prescale <= '0;
      r_uptime   <= r_uptime + 64'd1;
    end else if (r_en) begin
      r_prescale <= r_prescale + PW'(1);
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_en       <= 1'b1;
      r_ovf      <= 1'b0;
      r_scratch  <= '0;
      r_hiShadow <= '0;
    end else begin
      if (w_wrCtrl)
        r_en <= writedata[0];
      // Sticky overflow: a fresh set outranks a simultaneous write-1-to-clear.
      if (w_ovfSet)
        r_ovf <= 1'b1;
      else if (w_wrStatus && writedata[0])
        r_ovf <= 1'b0;
      if (w_rdUpLo)
        r_hiShadow <= r_uptime[63:32];
      for (int b = 0; b < 4; b++) begin
        if (w_wrScratch && byteenable[b])
          r_scratch[8*b +: 8] <= writedata[8*b +: 8];
      end
    end
  end

  always_comb begin
    w_rdata = '0;
    case (address)
      ADDR_W'(0): w_rdata = SYSTEM_ID;
      ADDR_W'(1): w_rdata = TIMESTAMP;
      ADDR_W'(2): w_rdata = r_uptime[31:0];
      ADDR_W'(3): w_rdata = r_hiShadow;
      ADDR_W'(4): w_rdata = r_scratch;
      ADDR_W'(5): w_rdata = {31'b0, r_en};
      ADDR_W'(6): w_rdata = {31'b0, r_ovf};
      default:    w_rdata = '0;
    endcase
  end

  // Data stages carry zero when empty so readdata is already 0 between pulses.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < READ_LATENCY; i++) begin
        r_pipeValid[i] <= 1'b0;
        r_pipeData[i]  <= '0;
      end
    end else begin
      r_pipeValid[0] <= read;
      r_pipeData[0]  <= read ? w_rdata : '0;
      for (int i = 1; i < READ_LATENCY; i++) begin
        r_pipeValid[i] <= r_pipeValid[i-1];
        r_pipeData[i]  <= r_pipeData[i-1];
      end
    end
  end

  assign readdatavalid = r_pipeValid[READ_LATENCY-1];
  assign readdata      = r_pipeData[READ_LATENCY-1];

endmodule

// File: tb/tb_nios2_sysid_regs.sv
// Bench for nios2_sysid_regs: latency-1 and latency-2 instances share stimulus and
// are checked every cycle against a register-map model, plus literal spot checks.
module tb_nios2_sysid_regs;

  localparam int          ADDR_W   = 4;
  localparam int          TICK_DIV = 3;
  localparam logic [31:0] SYS_ID   = 32'h5BBF_6F0A;
  localparam logic [31:0] TSTAMP   = 32'h6502_1A3C;
  localparam logic [63:0] UP_INIT  = 64'hFFFF_FFFF_FFFF_FFFA;

  logic              clock      = 1'b0;
  logic              reset_n    = 1'b0;
  logic [ADDR_W-1:0] address    = '0;
  logic              read       = 1'b0;
  logic              write      = 1'b0;
  logic [31:0]       writedata  = '0;
  logic [3:0]        byteenable = '0;
  logic [31:0]       rdData1, rdData2;
  logic              rdValid1, rdValid2;

  int nCompared   = 0;
  int nMismatched = 0;

  always #5 clock = ~clock;

  nios2_sysid_regs #(
    .SYSTEM_ID(SYS_ID), .TIMESTAMP(TSTAMP), .ADDR_W(ADDR_W),
    .READ_LATENCY(1), .TICK_DIV(TICK_DIV), .UPTIME_INIT(UP_INIT)
  ) dutL1 (
    .clock(clock), .reset_n(reset_n), .address(address), .read(read),
    .write(write), .writedata(writedata), .byteenable(byteenable),
    .readdata(rdData1), .readdatavalid(rdValid1)
  );

  nios2_sysid_regs #(
    .SYSTEM_ID(SYS_ID), .TIMESTAMP(TSTAMP), .ADDR_W(ADDR_W),
    .READ_LATENCY(2), .TICK_DIV(TICK_DIV), .UPTIME_INIT(UP_INIT)
  ) dutL2 (
    .clock(clock), .reset_n(reset_n), .address(address), .read(read),
    .write(write), .writedata(writedata), .byteenable(byteenable),
    .readdata(rdData2), .readdatavalid(rdValid2)
  );

  // Uptime is modelled as a base plus enabled cycles divided by TICK_DIV.
  logic [63:0] mBase    = UP_INIT;
  logic [63:0] mActive  = '0;
  logic        mEn      = 1'b1;
  logic        mOvf     = 1'b0;
  logic [31:0] mScratch = '0;
  logic [31:0] mHi      = '0;
  logic        exp1V    = 1'b0;
  logic        exp2V    = 1'b0;
  logic [31:0] exp1D    = '0;
  logic [31:0] exp2D    = '0;

  function automatic logic [63:0] mUptime();
    return mBase + mActive / 64'(TICK_DIV);
  endfunction

  function automatic bit mAboutToWrap();
    logic [63:0] u;
    u = mUptime();
    return mEn && (&u) && (mActive % 64'(TICK_DIV) == 64'(TICK_DIV - 1));
  endfunction

  task automatic modelReset();
    mBase = UP_INIT; mActive = '0; mEn = 1'b1; mOvf = 1'b0;
    mScratch = '0; mHi = '0;
    exp1V = 1'b0; exp2V = 1'b0; exp1D = '0; exp2D = '0;
  endtask

  task automatic modelStep();
    logic [63:0] oldUp;
    logic [63:0] newUp;
    logic [31:0] rd;
    logic        ovfSet;
    oldUp = mUptime();
    rd = '0;
    if (read) begin
      case (address)
        ADDR_W'(0): rd = SYS_ID;
        ADDR_W'(1): rd = TSTAMP;
        ADDR_W'(2): rd = oldUp[31:0];
        ADDR_W'(3): rd = mHi;
        ADDR_W'(4): rd = mScratch;
        ADDR_W'(5): rd = {31'b0, mEn};
        ADDR_W'(6): rd = {31'b0, mOvf};
        default:    rd = '0;
      endcase
    end
    exp2V = exp1V; exp2D = exp1D;
    exp1V = read;  exp1D = rd;
    if (read && address == ADDR_W'(2)) mHi = oldUp[63:32];
    ovfSet = 1'b0;
    if (write && address == ADDR_W'(5) && writedata[1]) begin
      mBase = '0; mActive = '0;
    end else if (mEn) begin
      mActive = mActive + 64'd1;
      newUp = mUptime();
      if (newUp != oldUp && newUp == 64'd0) ovfSet = 1'b1;
    end
    mOvf = ovfSet | (mOvf & !(write && address == ADDR_W'(6) && writedata[0]));
    if (write && address == ADDR_W'(5)) mEn = writedata[0];
    if (write && address == ADDR_W'(4))
      for (int b = 0; b < 4; b++)
        if (byteenable[b]) mScratch[8*b +: 8] = writedata[8*b +: 8];
  endtask

  initial forever begin
    @(posedge clock or negedge reset_n);
    if (!reset_n) modelReset();
    else          modelStep();
  end

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
    nCompared++;
    if (got !== exp) begin
      nMismatched++;
      if (nMismatched <= 20)
        $display("[TB] FAIL %s at %0t: got %08h, expected %08h", name, $time, got, exp);
    end
  endtask

  initial forever begin
    @(posedge clock);
    #2;
    checkOutput("lat1 valid", {31'b0, rdValid1}, {31'b0, exp1V});
    checkOutput("lat1 data",  rdData1, exp1D);
    checkOutput("lat2 valid", {31'b0, rdValid2}, {31'b0, exp2V});
    checkOutput("lat2 data",  rdData2, exp2D);
  end

  task automatic idle(input int n);
    read = 1'b0; write = 1'b0;
    repeat (n) @(negedge clock);
  endtask

  task automatic pulseReset();
    read = 1'b0; write = 1'b0; reset_n = 1'b0;
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
  endtask

  task automatic writeReg(input logic [ADDR_W-1:0] a, input logic [31:0] d, input logic [3:0] be);
    write = 1'b1; read = 1'b0; address = a; writedata = d; byteenable = be;
    @(negedge clock);
    write = 1'b0;
  endtask

  task automatic readLit(input logic [ADDR_W-1:0] a, input logic [31:0] exp, input string name);
    read = 1'b1; write = 1'b0; address = a;
    @(negedge clock);
    read = 1'b0;
    checkOutput({name, " valid"}, {31'b0, rdValid1}, 32'd1);
    checkOutput(name, rdData1, exp);
  endtask

  task automatic readWriteLit(input logic [ADDR_W-1:0] a, input logic [31:0] d,
                              input logic [3:0] be, input logic [31:0] exp, input string name);
    read = 1'b1; write = 1'b1; address = a; writedata = d; byteenable = be;
    @(negedge clock);
    read = 1'b0; write = 1'b0;
    checkOutput({name, " valid"}, {31'b0, rdValid1}, 32'd1);
    checkOutput(name, rdData1, exp);
  endtask

  task automatic waitOverflow(input string name);
    int n = 0;
    while (!mAboutToWrap() && n < 500) begin
      @(negedge clock);
      n++;
    end
    if (n >= 500) begin
      nCompared++;
      nMismatched++;
      $display("[TB] FAIL %s: no wrap within 500 cycles, got timeout, expected wrap", name);
    end
  endtask

  task automatic burst(input bit doReset, input int expPulses, input string name);
    int pulses = 0;
    for (int k = 0; k < 8; k++) begin
      if (rdValid2) pulses++;
      read = (k < 3);
      address = (k == 0) ? ADDR_W'(0) : (k == 1) ? ADDR_W'(4) : ADDR_W'(6);
      if (doReset && k == 3) reset_n = 1'b0;
      if (k == 6) reset_n = 1'b1;
      @(negedge clock);
    end
    checkOutput({name, " pulses"}, 32'(pulses), 32'(expPulses));
  endtask

  task automatic applyStimulus(input int cycles);
    for (int c = 0; c < cycles; c++) begin
      if ($urandom_range(0, 599) == 0) pulseReset();
      read       = ($urandom_range(0, 1) == 1);
      write      = ($urandom_range(0, 2) == 0);
      address    = ($urandom_range(0, 3) == 0) ? ADDR_W'($urandom_range(8, 15))
                                               : ADDR_W'($urandom_range(0, 7));
      writedata  = $urandom;
      byteenable = 4'($urandom_range(0, 15));
      if (address == ADDR_W'(5)) begin
        writedata[1] = ($urandom_range(0, 9) == 0);
        writedata[0] = ($urandom_range(0, 3) != 0);
      end
      @(negedge clock);
    end
    read = 1'b0; write = 1'b0;
  endtask

  initial begin
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    checkOutput("reset valid", {31'b0, rdValid1}, 32'd0);
    checkOutput("reset data", rdData1, 32'd0);
    readLit(ADDR_W'(0),  SYS_ID, "id");
    readLit(ADDR_W'(1),  TSTAMP, "tstamp");
    readLit(ADDR_W'(7),  32'd0,  "unmapped 7");
    readLit(ADDR_W'(15), 32'd0,  "unmapped 15");
    readLit(ADDR_W'(5),  32'd1,  "ctrl reset");
    readLit(ADDR_W'(6),  32'd0,  "status reset");
    readLit(ADDR_W'(3),  32'd0,  "hi shadow reset");

    waitOverflow("wrap");
    idle(1);
    readLit(ADDR_W'(6), 32'd1, "ovf set");
    readLit(ADDR_W'(2), 32'd0, "uptime lo wrapped");
    readLit(ADDR_W'(3), 32'd0, "uptime hi wrapped");
    writeReg(ADDR_W'(6), 32'd1, 4'hF);
    readLit(ADDR_W'(6), 32'd0, "ovf cleared");

    pulseReset();
    readLit(ADDR_W'(2), 32'hFFFF_FFFA, "uptime lo init");
    readLit(ADDR_W'(3), 32'hFFFF_FFFF, "hi shadow latched");
    waitOverflow("wrap again");
    writeReg(ADDR_W'(6), 32'd1, 4'hF);
    readLit(ADDR_W'(6), 32'd1, "ovf set beats clear");

    writeReg(ADDR_W'(4), 32'h1234_5678, 4'hF);
    writeReg(ADDR_W'(4), 32'hAABB_CCDD, 4'h5);
    readLit(ADDR_W'(4), 32'h12BB_56DD, "scratch bytes");
    readWriteLit(ADDR_W'(4), 32'h0, 4'hF, 32'h12BB_56DD, "scratch rw same cycle");
    readLit(ADDR_W'(4), 32'd0, "scratch after rw");

    writeReg(ADDR_W'(5), 32'd3, 4'hF);
    idle(39);
    readLit(ADDR_W'(2), 32'd13, "uptime 40 cycles");
    readLit(ADDR_W'(3), 32'd0,  "uptime hi");

    writeReg(ADDR_W'(5), 32'd2, 4'hF);
    idle(100);
    readLit(ADDR_W'(2), 32'd0, "uptime frozen");
    readLit(ADDR_W'(5), 32'd0, "ctrl en off");
    writeReg(ADDR_W'(5), 32'd3, 4'hF);
    idle(29);
    readLit(ADDR_W'(2), 32'd9, "uptime restart");

    idle(2);
    burst(1'b0, 3, "burst");
    idle(2);
    burst(1'b1, 2, "burst reset");

    applyStimulus(3000);
    idle(3);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
